// File: rtl/fir_sample_sequencer.sv
// fir_sample_sequencer
// Feeds samples from a small input FIFO into the FIR one at a time, waits for
// the FIR result and holds it in an output register behind a valid/ready
// handshake. A watchdog abandons a sample whose result never arrives and
// raises a sticky error flag.
module fir_sample_sequencer #(
    parameter int DATA_W  = 16,
    parameter int OUT_W   = 38,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,

    // Upstream sample stream
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,

    // FIR load side
    output logic [DATA_W-1:0] fir_input,
    output logic              fir_input_valid,

    // FIR result side
    input  logic [OUT_W-1:0]  fir_output,
    input  logic              fir_output_valid,

    // Downstream result stream
    output logic [OUT_W-1:0]  m_data,
    output logic              m_valid,
    input  logic              m_ready,

    // Status
    output logic              busy,
    output logic              timeout_err,
    output logic [15:0]       sample_count
);

    // FIFO pointers are log2(DEPTH) bits so they wrap modulo DEPTH for free;
    // the occupancy counter needs one extra bit to represent "full".
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW   = AW + 1;
    localparam int WD_W = $clog2(TIMEOUT);

    localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);
    localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    state_t            r_state;
    logic              r_fir_input_valid;
    logic [OUT_W-1:0]  r_m_data;
    logic              r_m_valid;
    logic              r_timeout_err;
    logic [15:0]       r_sample_count;
    logic [WD_W-1:0]   r_watchdog;

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Full/empty come straight from the registered occupancy, so a pop in
    // the same cycle never opens a slot early: s_ready stays low while full.
    assign w_full  = (r_count == FULL_COUNT);
    assign w_empty = (r_count == '0);
    assign w_push  = s_valid && !w_full;
    // ISSUE is only entered with a non-empty FIFO, so this pop is always legal.
    assign w_pop   = (r_state == ST_ISSUE);

    // Sample storage: write at the tail on every accepted push.
    // NOTE: the storage array is reset here only because it is a handful of
    // words and it makes fir_input a defined 0 after reset; a deeper buffer
    // would be left unreset and mapped onto RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= s_data;
        end
    end

    // Pointer and occupancy tracking; push and pop together cancel out.
    // NOTE: every clocked block uses non-blocking assignments so that all
    // registers update from the same pre-edge values, whatever the order of
    // the statements.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // ------------------------------------------------------------------
    // Issue one sample, wait for its result or the watchdog, then go idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state           <= ST_IDLE;
            r_fir_input_valid <= 1'b0;
            r_m_data          <= '0;
            r_m_valid         <= 1'b0;
            r_timeout_err     <= 1'b0;
            r_sample_count    <= '0;
            r_watchdog        <= '0;
        end else begin
            // Downstream consumed the held result. The capture in WAIT below
            // can never coincide with this, because ISSUE is only entered
            // with m_valid low.
            if (r_m_valid && m_ready) begin
                r_m_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    // Only one sample in flight: the previous result must
                    // have been taken before the next sample is issued.
                    if (!w_empty && !r_m_valid) begin
                        r_state           <= ST_ISSUE;
                        r_fir_input_valid <= 1'b1;
                    end
                end

                ST_ISSUE: begin
                    // The strobe lasts exactly this cycle; the FIFO pops at
                    // the closing edge.
                    r_fir_input_valid <= 1'b0;
                    r_watchdog        <= '0;
                    r_state           <= ST_WAIT;
                end

                ST_WAIT: begin
                    // A result on the watchdog's last cycle still wins.
                    if (fir_output_valid) begin
                        r_m_data       <= fir_output;
                        r_m_valid      <= 1'b1;
                        r_sample_count <= r_sample_count + 16'd1;
                        r_state        <= ST_IDLE;
                    end else if (r_watchdog == WD_LAST) begin
                        // Drop the sample, flag the FIR and keep running.
                        r_timeout_err <= 1'b1;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_watchdog <= r_watchdog + WD_W'(1);
                    end
                end

                default: begin
                    r_state           <= ST_IDLE;
                    r_fir_input_valid <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign s_ready         = !w_full;
    assign fir_input       = r_mem[r_rd_ptr];
    assign fir_input_valid = r_fir_input_valid;
    assign m_data          = r_m_data;
    assign m_valid         = r_m_valid;
    assign timeout_err     = r_timeout_err;
    assign sample_count    = r_sample_count;
    assign busy            = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: tb/tb_fir_sample_sequencer.sv
// Testbench for fir_sample_sequencer.
// A cycle-stepped environment drives the upstream stream and a behavioural FIR
// that answers a programmable number of cycles after each load strobe.
// Expected FIR inputs and expected results are queued when samples are
// accepted upstream and compared when the DUT strobes or presents a result.
module tb_fir_sample_sequencer;

    localparam int DATA_W  = 16;
    localparam int OUT_W   = 38;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    logic              clk;
    logic              reset;
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] fir_input;
    logic              fir_input_valid;
    logic [OUT_W-1:0]  fir_output;
    logic              fir_output_valid;
    logic [OUT_W-1:0]  m_data;
    logic              m_valid;
    logic              m_ready;
    logic              busy;
    logic              timeout_err;
    logic [15:0]       sample_count;

    fir_sample_sequencer #(
        .DATA_W  (DATA_W),
        .OUT_W   (OUT_W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .s_data           (s_data),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .fir_input        (fir_input),
        .fir_input_valid  (fir_input_valid),
        .fir_output       (fir_output),
        .fir_output_valid (fir_output_valid),
        .m_data           (m_data),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .busy             (busy),
        .timeout_err      (timeout_err),
        .sample_count     (sample_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bookkeeping
    int n_checks;
    int n_fail;
    int cyc;

    // Scoreboard queues
    logic [DATA_W-1:0] up_q[$];
    logic [DATA_W-1:0] exp_issue_q[$];
    logic [OUT_W-1:0]  exp_out_q[$];

    // FIR model: answers model_delay cycles after a strobe; 0 means never
    int               model_delay;
    int               model_cnt;
    logic [OUT_W-1:0] model_val;

    // Observations
    int               issue_count;
    int               last_issue_cyc;
    int               results_seen;
    int               last_rise_cyc;
    int               last_fov_cyc;
    int               accepted;
    int               push_cyc;
    logic             prev_mv;
    logic             prev_fiv;
    logic [OUT_W-1:0] prev_md;

    // Reference filter response used by the FIR model and the scoreboard.
    function automatic logic [OUT_W-1:0] fir_fn(input logic [DATA_W-1:0] x);
        return OUT_W'(x) << 4;
    endfunction

    // One clock cycle: observe outputs, run the FIR model, drive upstream.
    task automatic step();
        logic [DATA_W-1:0] e_in;
        logic [OUT_W-1:0]  e_out;
        @(negedge clk);
        cyc++;

        // m_ready still holds the value driven during the previous cycle.
        if (prev_mv === 1'b1 && m_ready === 1'b0) begin
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== prev_md) begin
                n_fail++;
                $display("FAIL hold: m_valid=%0b m_data=%0h, expected m_valid=1 m_data=%0h",
                         m_valid, m_data, prev_md);
            end
        end

        if (m_valid === 1'b1 && prev_mv !== 1'b1) begin
            results_seen++;
            last_rise_cyc = cyc;
            n_checks++;
            if (exp_out_q.size() == 0) begin
                n_fail++;
                $display("FAIL result_unexpected: m_data=%0h, expected no result", m_data);
            end else begin
                e_out = exp_out_q.pop_front();
                if (m_data !== e_out) begin
                    n_fail++;
                    $display("FAIL result_data: m_data=%0h, expected %0h", m_data, e_out);
                end
            end
        end
        prev_mv = m_valid;
        prev_md = m_data;

        // FIR model
        fir_output_valid = 1'b0;
        if (model_cnt > 0) begin
            model_cnt--;
            if (model_cnt == 0) begin
                fir_output_valid = 1'b1;
                fir_output       = model_val;
                last_fov_cyc     = cyc;
            end
        end
        if (fir_input_valid === 1'b1) begin
            issue_count++;
            last_issue_cyc = cyc;
            n_checks++;
            if (prev_fiv === 1'b1) begin
                n_fail++;
                $display("FAIL issue_pulse: fir_input_valid high 2 cycles, expected 1");
            end else if (exp_issue_q.size() == 0) begin
                n_fail++;
                $display("FAIL issue_unexpected: fir_input=%0h, expected no issue", fir_input);
            end else begin
                e_in = exp_issue_q.pop_front();
                if (fir_input !== e_in) begin
                    n_fail++;
                    $display("FAIL issue_data: fir_input=%0h, expected %0h", fir_input, e_in);
                end
            end
            if (model_delay > 0) begin
                model_cnt = model_delay;
                model_val = fir_fn(fir_input);
            end
        end
        prev_fiv = fir_input_valid;

        // Upstream: s_ready is stable until the next rising edge.
        if (up_q.size() > 0) begin
            s_valid = 1'b1;
            s_data  = up_q[0];
            if (s_ready === 1'b1) begin
                void'(up_q.pop_front());
                exp_issue_q.push_back(s_data);
                if (model_delay > 0) exp_out_q.push_back(fir_fn(s_data));
                accepted++;
                push_cyc = cyc;
            end
        end else begin
            s_valid = 1'b0;
            s_data  = '0;
        end
    endtask

    task automatic wait_result(input int budget, output bit ok);
        int r0;
        r0 = results_seen;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (results_seen > r0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_issue(input int budget, output bit ok);
        int i0;
        i0 = issue_count;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (issue_count > i0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        reset            = 1'b1;
        s_valid          = 1'b0;
        s_data           = '0;
        fir_output_valid = 1'b0;
        fir_output       = '0;
        m_ready          = 1'b0;
        model_delay      = 0;
        model_cnt        = 0;
        up_q.delete();
        exp_issue_q.delete();
        exp_out_q.delete();
        repeat (3) @(negedge clk);
        reset    = 1'b0;
        prev_mv  = 1'b0;
        prev_fiv = 1'b0;
        prev_md  = '0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({s_ready, fir_input_valid, m_valid, timeout_err, busy} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_flags: {s_ready,fiv,m_valid,timeout_err,busy}=%b, expected 10000",
                     {s_ready, fir_input_valid, m_valid, timeout_err, busy});
        end
        n_checks++;
        if (m_data !== '0) begin
            n_fail++;
            $display("FAIL reset_m_data: got %0h, expected 0", m_data);
        end
        n_checks++;
        if (sample_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0h, expected 0", sample_count);
        end
        n_checks++;
        if (fir_input !== '0) begin
            n_fail++;
            $display("FAIL reset_fir_input: got %0h, expected 0", fir_input);
        end
        repeat (3) step();
        reset = 1'b0;
        repeat (2) step();
        n_checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: s_ready=%0b busy=%0b m_valid=%0b, expected 1 0 0",
                     s_ready, busy, m_valid);
        end
    endtask

    task automatic test_single();
        bit ok;
        int i0;
        apply_reset();
        model_delay = 10;
        i0 = issue_count;
        up_q.push_back(16'h0100);
        wait_result(40, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL single_result_timeout: got no m_valid, expected one within 40 cycles");
        end
        n_checks++;
        if (issue_count - i0 != 1) begin
            n_fail++;
            $display("FAIL single_issue_count: got %0d, expected 1", issue_count - i0);
        end
        n_checks++;
        if (last_issue_cyc != push_cyc + 2) begin
            n_fail++;
            $display("FAIL single_issue_latency: got %0d, expected %0d", last_issue_cyc - push_cyc, 2);
        end
        n_checks++;
        if (last_rise_cyc != last_fov_cyc + 1) begin
            n_fail++;
            $display("FAIL single_result_latency: got %0d, expected 1", last_rise_cyc - last_fov_cyc);
        end
        n_checks++;
        if (m_data !== 38'h00_0000_1000 || sample_count !== 16'd1) begin
            n_fail++;
            $display("FAIL single_data_count: m_data=%0h count=%0d, expected 1000 and 1",
                     m_data, sample_count);
        end
        m_ready = 1'b1;
        repeat (2) step();
        n_checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drain: m_valid=%0b busy=%0b, expected 0 0", m_valid, busy);
        end
    endtask

    task automatic test_fifo_full();
        bit ok;
        int a0;
        int i0;
        int r0;
        apply_reset();
        model_delay = 3;
        // Park one result downstream so nothing issues while the FIFO fills.
        up_q.push_back(16'h00AA);
        wait_result(30, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL full_first_result: got no m_valid, expected one");
        end
        a0 = accepted;
        i0 = issue_count;
        r0 = results_seen;
        for (int i = 1; i <= 5; i++) up_q.push_back(DATA_W'(i));
        repeat (8) step();
        n_checks++;
        if (accepted - a0 != DEPTH || s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_accept: accepted=%0d s_ready=%0b, expected %0d and 0",
                     accepted - a0, s_ready, DEPTH);
        end
        n_checks++;
        if (issue_count != i0) begin
            n_fail++;
            $display("FAIL full_no_issue: got %0d issues, expected 0", issue_count - i0);
        end
        m_ready = 1'b1;
        for (int i = 0; i < 200 && results_seen < r0 + 5; i++) step();
        n_checks++;
        if (results_seen - r0 != 5 || sample_count !== 16'd6) begin
            n_fail++;
            $display("FAIL full_results: results=%0d count=%0d, expected 5 and 6",
                     results_seen - r0, sample_count);
        end
        n_checks++;
        if (exp_issue_q.size() != 0 || up_q.size() != 0) begin
            n_fail++;
            $display("FAIL full_drain: pending issue=%0d upstream=%0d, expected 0 0",
                     exp_issue_q.size(), up_q.size());
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int i0;
        int r;
        apply_reset();
        model_delay = 4;
        up_q.push_back(16'h1234);
        up_q.push_back(16'h5678);
        wait_result(30, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bp_first_result: got no m_valid, expected one");
        end
        i0 = issue_count;
        repeat (20) step();
        n_checks++;
        if (issue_count != i0 || m_valid !== 1'b1 || m_data !== fir_fn(16'h1234)) begin
            n_fail++;
            $display("FAIL bp_stall: issues=%0d m_valid=%0b m_data=%0h, expected 0 1 %0h",
                     issue_count - i0, m_valid, m_data, fir_fn(16'h1234));
        end
        m_ready = 1'b1;
        r = cyc;
        step();
        n_checks++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: m_valid=%0b, expected 0", m_valid);
        end
        step();
        n_checks++;
        if (issue_count != i0 + 1 || last_issue_cyc != r + 2) begin
            n_fail++;
            $display("FAIL bp_next_issue: issues=%0d at cycle offset %0d, expected 1 at 2",
                     issue_count - i0, last_issue_cyc - r);
        end
        wait_result(30, ok);
        n_checks++;
        if (!ok || sample_count !== 16'd2) begin
            n_fail++;
            $display("FAIL bp_second_result: seen=%0b count=%0d, expected 1 and 2", ok, sample_count);
        end
    endtask

    task automatic test_watchdog();
        bit ok;
        int s;
        int r0;
        int t_cyc;
        apply_reset();
        m_ready = 1'b1;
        up_q.push_back(16'h0BAD);
        wait_issue(10, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wd_issue: got no fir_input_valid, expected one");
        end
        s = last_issue_cyc;
        r0 = results_seen;
        t_cyc = -1;
        for (int i = 0; i < TIMEOUT + 10; i++) begin
            step();
            if (timeout_err === 1'b1 && t_cyc < 0) t_cyc = cyc;
        end
        n_checks++;
        if (t_cyc != s + TIMEOUT + 1) begin
            n_fail++;
            $display("FAIL wd_fire_time: got offset %0d, expected %0d", t_cyc - s, TIMEOUT + 1);
        end
        n_checks++;
        if (results_seen != r0 || m_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_drop: results=%0d m_valid=%0b busy=%0b, expected 0 0 0",
                     results_seen - r0, m_valid, busy);
        end
        model_delay = 5;
        up_q.push_back(16'h0042);
        wait_result(30, ok);
        n_checks++;
        if (!ok || timeout_err !== 1'b1 || sample_count !== 16'd1) begin
            n_fail++;
            $display("FAIL wd_recover: seen=%0b timeout_err=%0b count=%0d, expected 1 1 1",
                     ok, timeout_err, sample_count);
        end
    endtask

    task automatic test_coincidence();
        bit ok;
        int r0;
        apply_reset();
        m_ready = 1'b1;
        model_delay = TIMEOUT;
        up_q.push_back(16'h0077);
        wait_result(TIMEOUT + 20, ok);
        n_checks++;
        if (!ok || last_rise_cyc != last_issue_cyc + TIMEOUT + 1) begin
            n_fail++;
            $display("FAIL coinc_result: seen=%0b offset=%0d, expected 1 and %0d",
                     ok, last_rise_cyc - last_issue_cyc, TIMEOUT + 1);
        end
        n_checks++;
        if (timeout_err !== 1'b0 || sample_count !== 16'd1) begin
            n_fail++;
            $display("FAIL coinc_flags: timeout_err=%0b count=%0d, expected 0 and 1",
                     timeout_err, sample_count);
        end
        repeat (3) step();
        r0 = results_seen;
        fir_output       = 38'h3F_0000_0001;
        fir_output_valid = 1'b1;
        repeat (4) step();
        n_checks++;
        if (results_seen != r0 || m_valid !== 1'b0 || sample_count !== 16'd1) begin
            n_fail++;
            $display("FAIL stray_strobe: results=%0d m_valid=%0b count=%0d, expected 0 0 1",
                     results_seen - r0, m_valid, sample_count);
        end
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        int i0;
        int r0;
        apply_reset();
        m_ready = 1'b1;
        model_delay = 10;
        up_q.push_back(16'h0301);
        up_q.push_back(16'h0302);
        up_q.push_back(16'h0303);
        wait_issue(10, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rmw_issue: got no fir_input_valid, expected one");
        end
        repeat (3) step();
        reset = 1'b1;
        #1;
        n_checks++;
        if ({s_ready, fir_input_valid, m_valid, timeout_err, busy} !== 5'b10000
            || m_data !== '0 || sample_count !== 16'd0 || fir_input !== '0) begin
            n_fail++;
            $display("FAIL rmw_reset_values: flags=%b m_data=%0h count=%0d fir_input=%0h, expected 10000 0 0 0",
                     {s_ready, fir_input_valid, m_valid, timeout_err, busy}, m_data, sample_count, fir_input);
        end
        up_q.delete();
        exp_issue_q.delete();
        exp_out_q.delete();
        i0 = issue_count;
        r0 = results_seen;
        repeat (2) step();
        reset = 1'b0;
        repeat (12) step();
        n_checks++;
        if (results_seen != r0 || issue_count != i0 || m_valid !== 1'b0 || sample_count !== 16'd0) begin
            n_fail++;
            $display("FAIL rmw_late_strobe: results=%0d issues=%0d m_valid=%0b count=%0d, expected 0 0 0 0",
                     results_seen - r0, issue_count - i0, m_valid, sample_count);
        end
    endtask

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        cyc              = 0;
        issue_count      = 0;
        last_issue_cyc   = 0;
        results_seen     = 0;
        last_rise_cyc    = 0;
        last_fov_cyc     = 0;
        accepted         = 0;
        push_cyc         = 0;
        model_delay      = 0;
        model_cnt        = 0;
        model_val        = '0;
        prev_mv          = 1'b0;
        prev_fiv         = 1'b0;
        prev_md          = '0;
        reset            = 1'b0;
        s_valid          = 1'b0;
        s_data           = '0;
        fir_output_valid = 1'b0;
        fir_output       = '0;
        m_ready          = 1'b0;

        test_reset();
        test_single();
        test_fifo_full();
        test_backpressure();
        test_watchdog();
        test_coincidence();
        test_reset_mid_wait();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
